// File: rtl/fpm_pkg.sv
// Shared definitions for the FP16 multiplier FU sequencer: field positions,
// special encodings, FSM states, flag bit positions and FP16 class helpers.
package fpm_pkg;

  localparam int FP16_W  = 16;
  localparam int EXP_MSB = 14;
  localparam int EXP_LSB = 10;
  localparam int MAN_W   = 10;

  localparam logic [14:0] FP16_QNAN = 15'h7FFF;
  localparam logic [14:0] FP16_INF  = 15'h7C00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  localparam int FLAGS_W      = 3;
  localparam int FLAG_INVALID = 2;
  localparam int FLAG_INF     = 1;
  localparam int FLAG_ZERO    = 0;

  // Magnitude is exactly infinity (sign ignored).
  function automatic logic fp16_is_inf(input logic [FP16_W-1:0] x);
    return x[EXP_MSB:0] == FP16_INF;
  endfunction

  // Magnitude is zero (either signed zero).
  function automatic logic fp16_is_zero(input logic [FP16_W-1:0] x);
    return x[EXP_MSB:0] == 15'h0000;
  endfunction

  // All-ones exponent with a non-zero mantissa.
  function automatic logic fp16_is_nan(input logic [FP16_W-1:0] x);
    return (x[EXP_MSB:EXP_LSB] == 5'h1F) && (x[MAN_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/fpm_fu_ctrl_exc_detect.sv
// Combinational FP16 exception classifier for the multiplier result.
// Flags: {invalid, inf, zero}. Only instantiated with FPM_EXC_FLAGS_EN.
module fpm_exc_detect
  import fpm_pkg::*;
(
  input  logic [FP16_W-1:0]  a,
  input  logic [FP16_W-1:0]  b,
  input  logic [FP16_W-1:0]  p,
  output logic [FLAGS_W-1:0] flags
);

  // Invalid covers a NaN product and the Inf x 0 operand pairing, which a
  // multiplier may or may not already have turned into a NaN.
  always_comb begin
    flags               = '0;
    flags[FLAG_INVALID] = fp16_is_nan(p) ||
                          (fp16_is_inf(a) && fp16_is_zero(b)) ||
                          (fp16_is_zero(a) && fp16_is_inf(b));
    flags[FLAG_INF]     = fp16_is_inf(p);
    flags[FLAG_ZERO]    = fp16_is_zero(p);
  end

endmodule

// File: rtl/fpm_fu_ctrl.sv
// Sequencer around the FP16 multiplier FU: accepts an issue, holds operands
// at the multiplier for LATENCY cycles, captures the product and requests
// write-back until granted. Optional macro FPM_EXC_FLAGS_EN adds exception
// flag capture; without it wb_flags is constant zero.
//
// Handshakes: an issue transfers on a cycle with issue_valid && issue_ready;
// the issuer holds its request until then. A write-back transfers on a cycle
// with wb_req && wb_grant; wb_dst/wb_data/wb_flags are stable while wb_req is
// high and not granted. flush overrides both handshakes for that cycle.
module fpm_fu_ctrl
  import fpm_pkg::*;
#(
  parameter int LATENCY = 2,
  parameter int TAG_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [15:0]       issue_a,
  input  logic [15:0]       issue_b,
  input  logic [TAG_W-1:0]  issue_dst,
  input  logic              flush,
  output logic [15:0]       mul_a,
  output logic [15:0]       mul_b,
  input  logic [15:0]       mul_p,
  output logic              busy,
  output logic              wb_req,
  output logic [TAG_W-1:0]  wb_dst,
  output logic [15:0]       wb_data,
  input  logic              wb_grant,
  output logic [2:0]        wb_flags
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       accept;

`ifdef FPM_EXC_FLAGS_EN
  logic [FLAGS_W-1:0] flags_d;

  fpm_exc_detect u_exc_detect (
    .a     (mul_a),
    .b     (mul_b),
    .p     (mul_p),
    .flags (flags_d)
  );
`else
  assign wb_flags = 3'b000;
`endif

  // Ready in IDLE, or in WB when the result leaves this cycle; flush blocks.
  assign issue_ready = !flush && ((state == IDLE) || ((state == WB) && wb_grant));
  assign accept      = issue_valid && issue_ready;

  // Main FSM with registered busy/wb_req and operand/result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      mul_a    <= 16'h0000;
      mul_b    <= 16'h0000;
      wb_dst   <= '0;
      wb_data  <= 16'h0000;
      busy     <= 1'b0;
      wb_req   <= 1'b0;
`ifdef FPM_EXC_FLAGS_EN
      wb_flags <= 3'b000;
`endif
    end else if (flush) begin
      state  <= IDLE;
      busy   <= 1'b0;
      wb_req <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            mul_a  <= issue_a;
            mul_b  <= issue_b;
            wb_dst <= issue_dst;
            cnt    <= CNT_INIT;
            state  <= EXEC;
            busy   <= 1'b1;
          end
        end
        EXEC: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            wb_data  <= mul_p;
`ifdef FPM_EXC_FLAGS_EN
            wb_flags <= flags_d;
`endif
            state    <= WB;
            wb_req   <= 1'b1;
          end
        end
        WB: begin
          if (wb_grant) begin
            wb_req <= 1'b0;
            if (accept) begin
              mul_a  <= issue_a;
              mul_b  <= issue_b;
              wb_dst <= issue_dst;
              cnt    <= CNT_INIT;
              state  <= EXEC;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy   <= 1'b0;
          wb_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpm_fu_ctrl.sv
// Self-checking bench for fpm_fu_ctrl: directed vector table, hand-written
// back-to-back / flush / async-reset sequences, then randomized traffic
// checked against a transaction-level reference model.
module tb_fpm_fu_ctrl;

  localparam int LAT   = 2;
  localparam int TAG_W = 3;
  localparam int SB_W  = TAG_W + 16 + 3;
  localparam logic [15:0] JUNK = 16'hDEAD;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             issue_valid = 1'b0;
  logic             issue_ready;
  logic [15:0]      issue_a = '0;
  logic [15:0]      issue_b = '0;
  logic [TAG_W-1:0] issue_dst = '0;
  logic             flush = 1'b0;
  logic [15:0]      mul_a;
  logic [15:0]      mul_b;
  logic [15:0]      mul_p = '0;
  logic             busy;
  logic             wb_req;
  logic [TAG_W-1:0] wb_dst;
  logic [15:0]      wb_data;
  logic             wb_grant = 1'b0;
  logic [2:0]       wb_flags;

  int n_cmp = 0;
  int n_bad = 0;

  logic [SB_W-1:0] exp_q[$];

  fpm_fu_ctrl #(.LATENCY(LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_a(issue_a), .issue_b(issue_b), .issue_dst(issue_dst),
    .flush(flush),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .busy(busy),
    .wb_req(wb_req), .wb_dst(wb_dst), .wb_data(wb_data),
    .wb_grant(wb_grant), .wb_flags(wb_flags)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference flag classification from the FP16 encoding rules.
  function automatic logic [2:0] ref_flags(input logic [15:0] a, input logic [15:0] b,
                                           input logic [15:0] p);
`ifdef FPM_EXC_FLAGS_EN
    logic a_inf, b_inf, a_zero, b_zero, p_nan;
    a_inf  = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    p_nan  = (p[14:10] == 5'h1F) && (p[9:0] != 10'd0);
    return {p_nan || (a_inf && b_zero) || (a_zero && b_inf),
            (p[14:10] == 5'h1F) && (p[9:0] == 10'd0),
            p[14:0] == 15'd0};
`else
    return {1'b0, 1'b0, 1'b0 ^ (a[0] & 1'b0) ^ (b[0] & 1'b0) ^ (p[0] & 1'b0)};
`endif
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [15:0]      a;
    logic [15:0]      b;
    logic [15:0]      prod;
    logic [TAG_W-1:0] dst;
    int               hold;
    logic [2:0]       flags_en;
  } vec_t;

  vec_t vecs[4];

  // Wait for wb_req after an accepted issue; the multiplier stub presents the
  // real product only in the cycle the capture must happen.
  task automatic await_wb(input logic [15:0] a, input logic [15:0] prod,
                          input logic [TAG_W-1:0] dst, input logic [2:0] flags);
    int n;
    n = 1;
    while (!wb_req && n < 20) begin
      chk("busy_exec", busy, 1);
      chk("mul_a_hold", mul_a, a);
      chk("issue_ready_exec", issue_ready, 0);
      mul_p = (n == LAT) ? prod : JUNK;
      tick();
      n++;
    end
    mul_p = JUNK;
    chk("wb_latency", n, LAT + 1);
    chk("wb_data", wb_data, prod);
    chk("wb_dst", wb_dst, dst);
    chk("wb_flags", wb_flags, flags);
    chk("busy_wb", busy, 1);
  endtask

  task automatic run_vec(input vec_t v, input bit leave_in_wb);
    logic [2:0] fl;
`ifdef FPM_EXC_FLAGS_EN
    fl = v.flags_en;
`else
    fl = 3'b000;
`endif
    issue_valid = 1'b1; issue_a = v.a; issue_b = v.b; issue_dst = v.dst;
    wb_grant = (v.hold == 0); mul_p = JUNK;
    #1 chk("issue_ready_idle", issue_ready, 1);
    tick();
    issue_valid = 1'b0;
    await_wb(v.a, v.prod, v.dst, fl);
    for (int i = 0; i < v.hold; i++) begin
      wb_grant = 1'b0; issue_valid = 1'b1; issue_a = 16'h1234;
      #1 chk("issue_ready_hold", issue_ready, 0);
      tick();
      issue_valid = 1'b0;
      chk("wb_req_hold", wb_req, 1);
      chk("wb_data_hold", wb_data, v.prod);
      chk("wb_dst_hold", wb_dst, v.dst);
      chk("mul_a_ignored", mul_a, v.a);
    end
    if (!leave_in_wb) begin
      wb_grant = 1'b1; issue_valid = 1'b0;
      #1 chk("issue_ready_grant", issue_ready, 1);
      tick();
      wb_grant = 1'b0;
      chk("wb_req_released", wb_req, 0);
      chk("busy_released", busy, 0);
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    // reference model state for the random phase
    bit               m_exec, m_res;
    int               m_age;
    logic [15:0]      m_a, m_b, m_data;
    logic [TAG_W-1:0] m_dst;
    logic [2:0]       m_flags;
    logic             r_valid, r_grant, r_flush, exp_ready;
    logic [15:0]      r_a, r_b, r_p;
    logic [TAG_W-1:0] r_dst;
    logic [15:0]      specials[4];
    logic [SB_W-1:0]  exp_wb;

    vecs[0] = '{16'h4200, 16'h4000, 16'h4600, 3'd5, 0, 3'b000};
    vecs[1] = '{16'h3C00, 16'h3C00, 16'h3C00, 3'd2, 4, 3'b000};
    vecs[2] = '{16'h7C00, 16'h0000, 16'h7FFF, 3'd1, 0, 3'b100};
    vecs[3] = '{16'h0000, 16'h4200, 16'h0000, 3'd6, 1, 3'b001};
    specials[0] = 16'h0000; specials[1] = 16'h7C00;
    specials[2] = 16'h8000; specials[3] = 16'hFC00;

    // reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_wb_req", wb_req, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_flags", wb_flags, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_issue_ready", issue_ready, 1);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0);

    // back-to-back: grant and a new issue in the same WB cycle
    run_vec(vecs[1], 1'b1);
    wb_grant = 1'b1; issue_valid = 1'b1;
    issue_a = 16'h4000; issue_b = 16'h4000; issue_dst = 3'd3;
    #1 chk("b2b_issue_ready", issue_ready, 1);
    tick();
    issue_valid = 1'b0; wb_grant = 1'b0;
    chk("b2b_wb_req_drop", wb_req, 0);
    chk("b2b_mul_b", mul_b, 16'h4000);
    await_wb(16'h4000, 16'h4400, 3'd3, ref_flags(16'h4000, 16'h4000, 16'h4400));
    wb_grant = 1'b1;
    tick();
    wb_grant = 1'b0;
    chk("b2b_idle", busy, 0);

    // flush during EXEC with cnt=1
    issue_valid = 1'b1; issue_a = 16'h4200; issue_b = 16'h4000; issue_dst = 3'd7;
    mul_p = 16'h4600;
    tick();
    issue_valid = 1'b0;
    flush = 1'b1;
    #1 chk("flush_issue_ready", issue_ready, 0);
    tick();
    flush = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_wb_req", wb_req, 0);
    chk("flush_mul_a_kept", mul_a, 16'h4200);
    #1 chk("flush_issue_ready_after", issue_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_wb", wb_req, 0);
    end

    // asynchronous reset in the middle of WB
    run_vec(vecs[0], 1'b1);
    wb_grant = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_wb_req", wb_req, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mul_a", mul_a, 0);
    chk("arst_wb_dst", wb_dst, 0);
    #2 rst_n = 1'b1;
    tick();
    chk("arst_idle_busy", busy, 0);
    chk("arst_idle_ready", issue_ready, 1);

    // ---------------- randomized phase ----------------
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    m_exec = 0; m_res = 0; m_age = 0;
    m_a = '0; m_b = '0; m_data = '0; m_dst = '0; m_flags = '0;
    exp_q.delete();

    for (int cyc = 0; cyc < 1500; cyc++) begin
      chk("rnd_busy", busy, m_exec || m_res);
      chk("rnd_wb_req", wb_req, m_res);
      chk("rnd_wb_data", wb_data, m_data);
      chk("rnd_wb_dst", wb_dst, m_dst);
      chk("rnd_wb_flags", wb_flags, m_flags);
      chk("rnd_mul_a", mul_a, m_a);
      chk("rnd_mul_b", mul_b, m_b);

      r_valid = ($urandom_range(0, 1) == 1);
      r_grant = ($urandom_range(0, 2) != 0);
      r_flush = ($urandom_range(0, 15) == 0);
      r_a   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 16'($urandom);
      r_b   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 16'($urandom);
      r_p   = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 16'($urandom);
      r_dst = TAG_W'($urandom);
      issue_valid = r_valid; wb_grant = r_grant; flush = r_flush;
      issue_a = r_a; issue_b = r_b; mul_p = r_p; issue_dst = r_dst;

      exp_ready = !r_flush && ((!m_exec && !m_res) || (m_res && r_grant));
      #1 chk("rnd_issue_ready", issue_ready, exp_ready);

      // scoreboard: a granted write-back must match the oldest expected result
      if (wb_req && r_grant && !r_flush) begin
        chk("sb_not_empty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_wb = exp_q.pop_front();
          chk("sb_result", {wb_dst, wb_data, wb_flags}, exp_wb);
        end
      end

      tick();

      // reference model: an operation ages through LATENCY exec cycles
      if (r_flush) begin
        m_exec = 0; m_res = 0;
        exp_q.delete();
      end else if (m_exec) begin
        if (m_age == LAT - 1) begin
          m_exec = 0; m_res = 1;
          m_data = r_p;
          m_flags = ref_flags(m_a, m_b, r_p);
          exp_q.push_back({m_dst, m_data, m_flags});
        end else begin
          m_age++;
        end
      end else if (!m_res || r_grant) begin
        m_res = 0;
        if (r_valid) begin
          m_a = r_a; m_b = r_b; m_dst = r_dst;
          m_exec = 1; m_age = 0;
        end
      end
    end

    issue_valid = 1'b0; wb_grant = 1'b0; flush = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
